// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: one-hot operation codes, FSM encoding,
// operand width, iteration counts and the BCD-pair-to-binary helper.
package calc_pkg;

    localparam int OPND_W    = 7;
    localparam int MUL_ITERS = 7;
    localparam int DIV_ITERS = 10;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_CLR = 5'b10000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Non-decimal digits saturate to 9, so an operand never exceeds 99.
    function automatic logic [OPND_W-1:0] bcd_pair(input logic [3:0] tens, input logic [3:0] units);
        logic [OPND_W-1:0] t;
        logic [OPND_W-1:0] u;
        t = (tens  > 4'd9) ? 7'd9 : {3'b000, tens};
        u = (units > 4'd9) ? 7'd9 : {3'b000, units};
        return (t << 3) + (t << 1) + u;
    endfunction

endpackage

// File: rtl/calc_iter_engine.sv
// Shared iterative engine: shift-add multiply (one multiplier bit per cycle) or restoring
// divide of (a*10)/b (one quotient bit per cycle). result_next is the value after the current step.
module calc_iter_engine
    import calc_pkg::*;
#(
    parameter int RESULT_W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                div_mode,
    input  logic [OPND_W-1:0]   a,
    input  logic [OPND_W-1:0]   b,
    output logic                last,
    output logic [RESULT_W-1:0] result_next
);

    logic                running;
    logic                mode;
    logic [3:0]          cnt;
    logic [RESULT_W-1:0] acc;
    logic [RESULT_W-1:0] opa;
    logic [RESULT_W-1:0] a_ext;
    logic [OPND_W-1:0]   opb;
    logic [OPND_W:0]     rem;
    logic [OPND_W:0]     rem_n;
    logic [OPND_W:0]     trial;
    logic [OPND_W:0]     diff;
    logic                ge;

    assign a_ext = RESULT_W'(a);

    // A set remainder MSB means the shifted value already exceeds any 7-bit divisor.
    always_comb begin
        trial       = {rem[OPND_W-1:0], opa[DIV_ITERS-1]};
        diff        = trial - {1'b0, opb};
        ge          = rem[OPND_W] || (trial >= {1'b0, opb});
        rem_n       = rem;
        result_next = acc + (opb[0] ? opa : '0);
        if (mode) begin
            rem_n       = ge ? diff : trial;
            result_next = {acc[RESULT_W-2:0], ge};
        end
    end

    assign last = running && (cnt == (mode ? 4'(DIV_ITERS - 1) : 4'(MUL_ITERS - 1)));

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset as well, so an aborted run leaves no stale partial value.
        if (rst) begin
            running <= 1'b0;
            mode    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            rem     <= '0;
        end else if (start) begin
            running <= 1'b1;
            mode    <= div_mode;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opb     <= b;
            opa     <= div_mode ? (a_ext << 3) + (a_ext << 1) : a_ext;
        end else if (running) begin
            acc <= result_next;
            rem <= rem_n;
            opa <= opa << 1;
            opb <= mode ? opb : opb >> 1;
            cnt <= cnt + 4'd1;
            if (last) running <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: snapshots digits/operation, runs add/sub/clear locally and
// mul/div on calc_iter_engine. Optional divide-by-zero flagging under CALC_DIV_ERR_EN.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int RESULT_W = 14,
    parameter int BCD_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BCD_W-1:0]    dig1,
    input  logic [BCD_W-1:0]    dig2,
    input  logic [BCD_W-1:0]    dig3,
    input  logic [BCD_W-1:0]    dig4,
    input  logic [4:0]          operation,
    output logic [RESULT_W-1:0] result,
    output logic                negative_sign,
    output logic                dot,
    output logic                busy,
    output logic                done
`ifdef CALC_DIV_ERR_EN
    ,
    output logic                div_err
`endif
);

    logic [1:0]          state;
    logic [1:0]          state_n;
    logic [4:0]          snap_op;
    logic [4*BCD_W-1:0]  snap_dig;
    logic [OPND_W-1:0]   opnd_a;
    logic [OPND_W-1:0]   opnd_b;
    logic [OPND_W:0]     sum_ab;
    logic [OPND_W-1:0]   diff_ab;
    logic                start_req;
    logic                use_engine;
    logic                eng_start;
    logic                eng_last;
    logic                div_skip;
    logic                finish;
    logic [RESULT_W-1:0] eng_result;
    logic [RESULT_W-1:0] res_n;
    logic                neg_n;
    logic                dot_n;

    assign opnd_a = bcd_pair(snap_dig[4*BCD_W-1:3*BCD_W], snap_dig[3*BCD_W-1:2*BCD_W]);
    assign opnd_b = bcd_pair(snap_dig[2*BCD_W-1:BCD_W],   snap_dig[BCD_W-1:0]);

    // A run starts only when the requested work differs from what was last computed.
    assign start_req  = $onehot(operation) &&
                        ({operation, dig4, dig3, dig2, dig1} != {snap_op, snap_dig});
    assign use_engine = (snap_op == OP_MUL) || (snap_op == OP_DIV);

`ifdef CALC_DIV_ERR_EN
    assign div_skip = (snap_op == OP_DIV) && (opnd_b == '0);
`else
    assign div_skip = 1'b0;
`endif

    assign eng_start = (state == ST_LOAD) && use_engine && !div_skip;

    calc_iter_engine #(.RESULT_W(RESULT_W)) u_engine (
        .clk         (clk),
        .rst         (rst),
        .start       (eng_start),
        .div_mode    (snap_op == OP_DIV),
        .a           (opnd_a),
        .b           (opnd_b),
        .last        (eng_last),
        .result_next (eng_result)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start_req) state_n = ST_LOAD;
            ST_LOAD: state_n = div_skip ? ST_DONE : ST_EXEC;
            ST_EXEC: if (!use_engine || eng_last) state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign finish = (state_n == ST_DONE) && (state != ST_DONE);
    assign sum_ab = {1'b0, opnd_a} + {1'b0, opnd_b};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        res_n   = '0;
        neg_n   = 1'b0;
        dot_n   = 1'b1;
        diff_ab = (opnd_b > opnd_a) ? opnd_b - opnd_a : opnd_a - opnd_b;
        if (!div_skip) begin
            case (snap_op)
                OP_ADD: res_n = RESULT_W'(sum_ab);
                OP_SUB: begin
                    res_n = RESULT_W'(diff_ab);
                    neg_n = opnd_b > opnd_a;
                end
                OP_MUL: res_n = eng_result;
                OP_DIV: begin
                    res_n = eng_result;
                    dot_n = 1'b0;
                end
                default: res_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register here samples pre-edge values.
        if (rst) begin
            state         <= ST_IDLE;
            snap_op       <= '0;
            snap_dig      <= '0;
            result        <= '0;
            negative_sign <= 1'b0;
            dot           <= 1'b1;
`ifdef CALC_DIV_ERR_EN
            div_err       <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == ST_IDLE && start_req) begin
                snap_op  <= operation;
                snap_dig <= {dig4, dig3, dig2, dig1};
            end
            if (finish) begin
                result        <= res_n;
                negative_sign <= neg_n;
                dot           <= dot_n;
`ifdef CALC_DIV_ERR_EN
                div_err       <= div_skip;
`endif
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: latency, arithmetic results, flags, retrigger, hold and abort.
// Define CALC_DIV_ERR_EN for both RTL and bench to exercise the divide-by-zero flag.
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dig1, dig2, dig3, dig4;
    logic [4:0]  operation;
    logic [13:0] result;
    logic        negative_sign, dot, busy, done;
`ifdef CALC_DIV_ERR_EN
    logic        div_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    calc_op_sequencer #(.RESULT_W(14), .BCD_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .dig1          (dig1),
        .dig2          (dig2),
        .dig3          (dig3),
        .dig4          (dig4),
        .operation     (operation),
        .result        (result),
        .negative_sign (negative_sign),
        .dot           (dot),
        .busy          (busy),
        .done          (done)
`ifdef CALC_DIV_ERR_EN
        ,
        .div_err       (div_err)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] d4, input logic [3:0] d3,
                         input logic [3:0] d2, input logic [3:0] d1);
        operation = op;
        dig4 = d4;
        dig3 = d3;
        dig2 = d2;
        dig1 = d1;
    endtask

    // cycles = edges from the drive point to the first sampled done, or -1 if none within budget
    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget && cycles < 0; c++) begin
            step();
            if (done === 1'b1) cycles = c;
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [3:0] d4, input logic [3:0] d3,
                          input logic [3:0] d2, input logic [3:0] d1, output int cycles);
        drive(op, d4, d3, d2, d1);
        wait_done(30, cycles);
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1;
        drive(5'b00000, 4'd0, 4'd0, 4'd0, 4'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++; if (result !== 14'd0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result); end
        vectors++; if (dot !== 1'b1) begin miscompares++; $display("FAIL reset_dot: got %b expected 1", dot); end
        vectors++; if (negative_sign !== 1'b0) begin miscompares++; $display("FAIL reset_neg: got %b expected 0", negative_sign); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef CALC_DIV_ERR_EN
        vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
`endif
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL reset_no_done: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_add_sub();
        int lat;
        run_op(5'b00001, 4'd4, 4'd5, 4'd2, 4'd7, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL add_latency: got %0d expected 3", lat); end
        vectors++; if (result !== 14'd72) begin miscompares++; $display("FAIL add_result: got %0d expected 72", result); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL add_busy_at_done: got %b expected 1", busy); end
        step();
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL add_release: got busy=%b done=%b expected 0 0", busy, done); end
        run_op(5'b00010, 4'd4, 4'd5, 4'd2, 4'd7, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sub_latency: got %0d expected 3", lat); end
        vectors++; if (result !== 14'd18 || negative_sign !== 1'b0) begin miscompares++; $display("FAIL sub_pos: got %0d neg=%b expected 18 neg=0", result, negative_sign); end
        step();
    endtask

    task automatic test_sub_mul();
        int lat;
        run_op(5'b00010, 4'd1, 4'd2, 4'd3, 4'd4, lat);
        vectors++; if (result !== 14'd22 || negative_sign !== 1'b1) begin miscompares++; $display("FAIL sub_neg: got %0d neg=%b expected 22 neg=1", result, negative_sign); end
        step();
        run_op(5'b00100, 4'd9, 4'd9, 4'd9, 4'd9, lat);
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL mul_latency: got %0d expected 9", lat); end
        vectors++; if (result !== 14'd9801 || negative_sign !== 1'b0 || dot !== 1'b1) begin miscompares++; $display("FAIL mul_max: got %0d neg=%b dot=%b expected 9801 neg=0 dot=1", result, negative_sign, dot); end
        step();
    endtask

    task automatic test_boundary();
        int lat;
        run_op(5'b00001, 4'hF, 4'hA, 4'd0, 4'd1, lat);
        vectors++; if (result !== 14'd100) begin miscompares++; $display("FAIL clamp_add: got %0d expected 100", result); end
        step();
        run_op(5'b00010, 4'd2, 4'd0, 4'd3, 4'd0, lat);
        vectors++; if (result !== 14'd10 || negative_sign !== 1'b1) begin miscompares++; $display("FAIL sub_20_30: got %0d neg=%b expected 10 neg=1", result, negative_sign); end
        step();
        run_op(5'b00010, 4'd3, 4'd0, 4'd3, 4'd0, lat);
        vectors++; if (result !== 14'd0 || negative_sign !== 1'b0) begin miscompares++; $display("FAIL sub_equal: got %0d neg=%b expected 0 neg=0", result, negative_sign); end
        step();
    endtask

    task automatic test_div();
        int lat;
        run_op(5'b01000, 4'd2, 4'd2, 4'd0, 4'd7, lat);
        vectors++; if (lat !== 12) begin miscompares++; $display("FAIL div_latency: got %0d expected 12", lat); end
        vectors++; if (result !== 14'd31 || dot !== 1'b0) begin miscompares++; $display("FAIL div_result: got %0d dot=%b expected 31 dot=0", result, dot); end
        step();
    endtask

    task automatic test_clear();
        int lat;
        run_op(5'b10000, 4'd2, 4'd2, 4'd0, 4'd7, lat);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL clear_latency: got %0d expected 3", lat); end
        vectors++; if (result !== 14'd0 || dot !== 1'b1) begin miscompares++; $display("FAIL clear_after_div: got %0d dot=%b expected 0 dot=1", result, dot); end
        step();
        run_op(5'b00010, 4'd1, 4'd0, 4'd2, 4'd0, lat);
        vectors++; if (negative_sign !== 1'b1) begin miscompares++; $display("FAIL pre_clear_neg: got %b expected 1", negative_sign); end
        step();
        run_op(5'b10000, 4'd1, 4'd0, 4'd2, 4'd0, lat);
        vectors++; if (result !== 14'd0 || negative_sign !== 1'b0) begin miscompares++; $display("FAIL clear_after_sub: got %0d neg=%b expected 0 neg=0", result, negative_sign); end
        step();
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(5'b01000, 4'd2, 4'd2, 4'd0, 4'd0, lat);
`ifdef CALC_DIV_ERR_EN
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL div0_latency: got %0d expected 2", lat); end
        vectors++; if (result !== 14'd0 || dot !== 1'b1 || div_err !== 1'b1) begin miscompares++; $display("FAIL div0_flags: got %0d dot=%b err=%b expected 0 dot=1 err=1", result, dot, div_err); end
        step();
        run_op(5'b00001, 4'd2, 4'd2, 4'd0, 4'd0, lat);
        vectors++; if (result !== 14'd22 || div_err !== 1'b0) begin miscompares++; $display("FAIL div0_err_clear: got %0d err=%b expected 22 err=0", result, div_err); end
`else
        vectors++; if (lat !== 12) begin miscompares++; $display("FAIL div0_latency: got %0d expected 12", lat); end
        vectors++; if (result !== 14'd1023 || dot !== 1'b0) begin miscompares++; $display("FAIL div0_result: got %0d dot=%b expected 1023 dot=0", result, dot); end
`endif
        step();
    endtask

    task automatic test_retrigger();
        int lat;
        int pulses = 0;
        drive(5'b00100, 4'd1, 4'd3, 4'd0, 4'd5);
        for (int c = 0; c < 3; c++) step();
        dig1 = 4'd6;
        wait_done(30, lat);
        vectors++; if (lat !== 6) begin miscompares++; $display("FAIL retrig_first_latency: got %0d expected 6", lat); end
        vectors++; if (result !== 14'd65) begin miscompares++; $display("FAIL retrig_first: got %0d expected 65", result); end
        wait_done(30, lat);
        vectors++; if (lat !== 10) begin miscompares++; $display("FAIL retrig_second_latency: got %0d expected 10", lat); end
        vectors++; if (result !== 14'd78) begin miscompares++; $display("FAIL retrig_second: got %0d expected 78", result); end
        step();
        drive(5'b00110, 4'd9, 4'd9, 4'd9, 4'd9);
        for (int c = 0; c < 15; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL multihot_no_start: got pulses=%0d busy=%b expected 0 0", pulses, busy); end
        vectors++; if (result !== 14'd78) begin miscompares++; $display("FAIL multihot_hold: got %0d expected 78", result); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        drive(5'b01000, 4'd2, 4'd2, 4'd0, 4'd7);
        for (int c = 0; c < 5; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy: got %b expected 1", busy); end
        rst = 1'b1;
        operation = 5'b00000;
        step();
        if (done === 1'b1) pulses++;
        vectors++; if (result !== 14'd0 || dot !== 1'b1 || negative_sign !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %0d dot=%b neg=%b busy=%b expected 0 1 0 0", result, dot, negative_sign, busy);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0 || result !== 14'd0) begin miscompares++; $display("FAIL abort_no_done: got pulses=%0d result=%0d expected 0 0", pulses, result); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_sub_mul();
        test_boundary();
        test_div();
        test_clear();
        test_div_zero();
        test_retrigger();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
